// File: rtl/param_stack.sv
// param_stack: parameterised LIFO stack with replace-top, registered pop data and sticky error flags
//   clk, reset(async, active-high)      clock and reset
//   push, pop, data_in                  request a push, a pop, or both (replace top)
//   clear_err                           synchronous clear of the sticky error flags
//   top                                 current top entry, 0 when empty
//   pop_data, pop_valid                 word removed by the last accepted pop, one-cycle strobe
//   count, full, empty                  occupancy
//   overflow_err, underflow_err         sticky error flags
//   STACK_PEEK_EN adds peek_idx/peek_data/peek_valid for read-only access below the top
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear_err,
`ifdef STACK_PEEK_EN
    input  logic [AW-1:0]    peek_idx,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_valid,
`endif
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow_err,
    output logic             underflow_err
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d, cnt_m1;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [AW-1:0]    top_idx, wr_idx;
    logic             wr_en;

    assign cnt_m1  = count_q - CW'(1);
    assign top_idx = cnt_m1[AW-1:0];
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign top     = empty ? '0 : mem_q[top_idx];

    assign count         = count_q;
    assign pop_data      = pop_data_q;
    assign pop_valid     = pop_valid_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

    // A fresh error in the same cycle as clear_err wins because it is applied after the clear
    always_comb begin
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q & ~clear_err;
        unf_d       = unf_q & ~clear_err;
        wr_en       = 1'b0;
        wr_idx      = count_q[AW-1:0];
        if (push && pop) begin
            wr_en = 1'b1;
            if (empty) begin
                count_d = CW'(1);
                unf_d   = 1'b1;
            end else begin
                wr_idx      = top_idx;
                pop_data_d  = mem_q[top_idx];
                pop_valid_d = 1'b1;
            end
        end else if (push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                pop_data_d  = mem_q[top_idx];
                pop_valid_d = 1'b1;
                count_d     = cnt_m1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage is not reset; a write is suppressed while reset is held so nothing leaks past it
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem_q[wr_idx] <= data_in;
    end

`ifdef STACK_PEEK_EN
    logic [AW-1:0] peek_pos;
    assign peek_pos   = top_idx - peek_idx;
    assign peek_valid = CW'(peek_idx) < count_q;
    assign peek_data  = peek_valid ? mem_q[peek_pos] : '0;
`endif
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: vector table plus scoreboard of pop data for param_stack (WIDTH=8, DEPTH=4)
module tb_param_stack;
    logic       clk = 1'b0;
    logic       reset, push, pop, clear_err;
    logic [7:0] data_in;
    logic [7:0] top, pop_data;
    logic       pop_valid, full, empty, overflow_err, underflow_err;
    logic [2:0] count;
`ifdef STACK_PEEK_EN
    logic [1:0] peek_idx;
    logic [7:0] peek_data;
    logic       peek_valid;
`endif

    param_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .clear_err(clear_err),
`ifdef STACK_PEEK_EN
        .peek_idx(peek_idx), .peek_data(peek_data), .peek_valid(peek_valid),
`endif
        .top(top), .pop_data(pop_data), .pop_valid(pop_valid), .count(count),
        .full(full), .empty(empty), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic       clr;
        logic [2:0] cnt;
        logic [7:0] top;
        logic       ovf;
        logic       unf;
        logic       pv;
        logic [7:0] pd;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_pd = 8'h00;
    vec_t       tbl [20];

    function automatic vec_t mk(input int pu, po, d, c, n, t, o, u, pv, pd);
        vec_t r;
        r.push = pu[0]; r.pop = po[0]; r.din = d[7:0]; r.clr = c[0];
        r.cnt = n[2:0]; r.top = t[7:0]; r.ovf = o[0]; r.unf = u[0];
        r.pv = pv[0]; r.pd = pd[7:0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v);
        push = v.push; pop = v.pop; data_in = v.din; clear_err = v.clr;
        if (v.pv) begin
            sb_q.push_back(v.pd);
            last_pd = v.pd;
        end
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear_err = 1'b0;
        chk("count", 32'(count), 32'(v.cnt));
        chk("top", 32'(top), 32'(v.top));
        chk("full", 32'(full), 32'(v.cnt == 3'd4));
        chk("empty", 32'(empty), 32'(v.cnt == 3'd0));
        chk("overflow_err", 32'(overflow_err), 32'(v.ovf));
        chk("underflow_err", 32'(underflow_err), 32'(v.unf));
        chk("pop_valid", 32'(pop_valid), 32'(v.pv));
        if (pop_valid) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_sb: got unexpected pop_data %0h with no expected entry", pop_data);
            end else begin
                chk("pop_sb", 32'(pop_data), 32'(sb_q.pop_front()));
            end
        end
        chk("pop_data_hold", 32'(pop_data), 32'(last_pd));
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 'h11, 0, 1, 'h11, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 'h22, 0, 2, 'h22, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 'h33, 0, 3, 'h33, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 'h44, 0, 4, 'h44, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 'h55, 0, 4, 'h44, 1, 0, 0, 0);
        tbl[5]  = mk(0, 1, 'h00, 0, 3, 'h33, 1, 0, 1, 'h44);
        tbl[6]  = mk(0, 1, 'h00, 0, 2, 'h22, 1, 0, 1, 'h33);
        tbl[7]  = mk(0, 1, 'h00, 0, 1, 'h11, 1, 0, 1, 'h22);
        tbl[8]  = mk(0, 1, 'h00, 0, 0, 'h00, 1, 0, 1, 'h11);
        tbl[9]  = mk(0, 1, 'h00, 0, 0, 'h00, 1, 1, 0, 0);
        tbl[10] = mk(1, 0, 'h0A, 0, 1, 'h0A, 1, 1, 0, 0);
        tbl[11] = mk(1, 1, 'h0B, 0, 1, 'h0B, 1, 1, 1, 'h0A);
        tbl[12] = mk(1, 0, 'h01, 1, 2, 'h01, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 'h02, 0, 3, 'h02, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 'h03, 0, 4, 'h03, 0, 0, 0, 0);
        tbl[15] = mk(1, 1, 'hC3, 0, 4, 'hC3, 0, 0, 1, 'h03);
        tbl[16] = mk(1, 0, 'h55, 1, 4, 'hC3, 1, 0, 0, 0);
        tbl[17] = mk(0, 0, 'h00, 1, 4, 'hC3, 0, 0, 0, 0);
        tbl[18] = mk(1, 0, 'hAA, 0, 4, 'hC3, 1, 0, 0, 0);
        tbl[19] = mk(0, 1, 'h00, 0, 3, 'h02, 1, 0, 1, 'hC3);

        reset = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; data_in = 8'h00;
`ifdef STACK_PEEK_EN
        peek_idx = 2'd0;
`endif
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_top", 32'(top), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_pop_data", 32'(pop_data), 32'd0);
        chk("rst_flags", 32'({overflow_err, underflow_err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) step(tbl[i]);

        // Asynchronous reset in the middle of a cycle with a push pending
        push = 1'b1; data_in = 8'hEE;
        #3;
        reset = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_top", 32'(top), 32'd0);
        chk("async_pop_valid", 32'(pop_valid), 32'd0);
        chk("async_pop_data", 32'(pop_data), 32'd0);
        chk("async_flags", 32'({overflow_err, underflow_err}), 32'd0);
        sb_q.delete();
        last_pd = 8'h00;
        @(posedge clk);
        push = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(mk(0, 1, 'h00, 0, 0, 'h00, 0, 1, 0, 0));
        step(mk(1, 1, 'h5A, 1, 1, 'h5A, 0, 1, 0, 0));
        step(mk(0, 1, 'h00, 0, 0, 'h00, 0, 1, 1, 'h5A));
        step(mk(1, 0, 'h11, 0, 1, 'h11, 0, 1, 0, 0));
        step(mk(1, 0, 'h22, 0, 2, 'h22, 0, 1, 0, 0));
        step(mk(1, 0, 'h33, 0, 3, 'h33, 0, 1, 0, 0));

`ifdef STACK_PEEK_EN
        peek_idx = 2'd0; #1;
        chk("peek0_data", 32'(peek_data), 32'h33);
        chk("peek0_valid", 32'(peek_valid), 32'd1);
        peek_idx = 2'd1; #1;
        chk("peek1_data", 32'(peek_data), 32'h22);
        peek_idx = 2'd2; #1;
        chk("peek2_data", 32'(peek_data), 32'h11);
        chk("peek2_valid", 32'(peek_valid), 32'd1);
        peek_idx = 2'd3; #1;
        chk("peek3_data", 32'(peek_data), 32'h00);
        chk("peek3_valid", 32'(peek_valid), 32'd0);
        chk("peek_count", 32'(count), 32'd3);
`endif

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
